// File: rtl/mcs4_axi_pkg.sv
// Shared types and constants for the mcs4 AXI4 loader (command-driven burst master).
package mcs4_axi_pkg;

    localparam int MCS4_AXI_ADDR_W = 14;
    localparam int MCS4_AXI_DATA_W = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } loader_state_e;

endpackage

// File: rtl/mcs4_axi_loader.sv
// Command-driven AXI4 INCR burst master feeding the mcs4_sys slave port.
// Define MCS4_AXI_LOADER_BRESP_EN to wait for and check the B channel on writes.
module mcs4_axi_loader
    import mcs4_axi_pkg::*;
#(
    parameter int ADDR_W = MCS4_AXI_ADDR_W,
    parameter int DATA_W = MCS4_AXI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,

    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,

    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,

    output logic              done,
    output logic              cmd_err,
    output logic              err,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,

    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,

    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic [2:0]        o_dbg_state
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("mcs4_axi_loader: DATA_W must be 32");
        end
    endgenerate

    // Handshake rule on every channel: a transfer happens on a rising clk edge
    // where valid and ready are both high; a raised valid is held until its ready.

    // (len+1)*4 needs up to 11 bits on top of the address width.
    localparam int SUM_W = ADDR_W + 11;
    localparam logic [SUM_W-1:0] ADDR_LIMIT = SUM_W'(1) << ADDR_W;

    loader_state_e     r_state;
    loader_state_e     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_beat_cnt;
    logic              r_done;
    logic              r_cmd_err;
    logic              r_err;

    logic [ADDR_W-1:0] w_start_addr;
    logic [SUM_W-1:0]  w_end_addr;
    logic              w_range_bad;
    logic              w_cmd_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_last_beat;

    assign w_start_addr = {cmd_addr[ADDR_W-1:2], 2'b00};
    assign w_end_addr   = SUM_W'(w_start_addr) + ((SUM_W'(cmd_len) + SUM_W'(1)) << 2);
    assign w_range_bad  = (w_end_addr > ADDR_LIMIT);

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign w_cmd_hs    = cmd_valid && cmd_ready;
    assign w_last_beat = (r_beat_cnt == r_len);

    // Handshakes are built from state and raw inputs so they never loop back
    // through the gated outputs produced below.
    assign w_aw_hs = (r_state == ST_AW) && m_axi_awready;
    assign w_w_hs  = (r_state == ST_W)  && wr_valid && m_axi_wready;
    assign w_ar_hs = (r_state == ST_AR) && m_axi_arready;
    assign w_r_hs  = (r_state == ST_R)  && m_axi_rvalid && rd_ready;

    assign m_axi_awaddr = r_addr;
    assign m_axi_awlen  = r_len;
    assign m_axi_araddr = r_addr;
    assign m_axi_arlen  = r_len;
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = 4'hF;
    assign rd_data      = m_axi_rdata;

    assign done        = r_done;
    assign cmd_err     = r_cmd_err;
    assign err         = r_err;
    assign o_dbg_state = r_state;

`ifdef MCS4_AXI_LOADER_BRESP_EN
    logic w_b_hs;
    logic w_unused;
    assign w_b_hs       = (r_state == ST_B) && m_axi_bvalid;
    assign m_axi_bready = (r_state == ST_B);
    assign w_unused     = ^cmd_addr[1:0];
`else
    // The system tie-off never drives B, so the response is accepted and ignored.
    logic w_unused;
    assign m_axi_bready = 1'b1;
    assign w_unused     = ^{cmd_addr[1:0], m_axi_bvalid, m_axi_bresp};
`endif

    always_comb begin
        w_next_state  = r_state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_arvalid = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        m_axi_rready  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs && !w_range_bad) begin
                    w_next_state = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                if (w_aw_hs) begin
                    w_next_state = ST_W;
                end
            end
            ST_W: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wlast  = w_last_beat;
                if (w_w_hs && w_last_beat) begin
`ifdef MCS4_AXI_LOADER_BRESP_EN
                    w_next_state = ST_B;
`else
                    w_next_state = ST_IDLE;
`endif
                end
            end
`ifdef MCS4_AXI_LOADER_BRESP_EN
            ST_B: begin
                if (w_b_hs) begin
                    w_next_state = ST_IDLE;
                end
            end
`endif
            ST_AR: begin
                m_axi_arvalid = 1'b1;
                if (w_ar_hs) begin
                    w_next_state = ST_R;
                end
            end
            ST_R: begin
                rd_valid     = m_axi_rvalid;
                m_axi_rready = rd_ready;
                rd_last      = w_last_beat;
                // Completion follows the local count, not the slave's RLAST.
                if (w_r_hs && w_last_beat) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;

            if (w_cmd_hs) begin
                r_addr     <= w_start_addr;
                r_len      <= cmd_len;
                r_beat_cnt <= '0;
                r_cmd_err  <= w_range_bad;
            end

            if (w_w_hs || w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end

            if (w_r_hs) begin
                if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != w_last_beat)) begin
                    r_err <= 1'b1;
                end
                if (w_last_beat) begin
                    r_done <= 1'b1;
                end
            end

`ifdef MCS4_AXI_LOADER_BRESP_EN
            if (w_b_hs) begin
                r_done <= 1'b1;
                if (m_axi_bresp != AXI_RESP_OKAY) begin
                    r_err <= 1'b1;
                end
            end
`else
            if (w_w_hs && w_last_beat) begin
                r_done <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mcs4_axi_loader.sv
// Directed bench for mcs4_axi_loader (default build: no B channel wait).
module tb_mcs4_axi_loader;
    import mcs4_axi_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_valid;
    logic          rd_ready;
    logic          done;
    logic          cmd_err;
    logic          err;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [2:0]    dbg_state;

    mcs4_axi_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .cmd_err(cmd_err), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    int aw_hs_cnt = 0;
    int ar_hs_cnt = 0;
    int w_hs_cnt  = 0;
    int rd_hs_cnt = 0;
    int done_cnt  = 0;

    always @(negedge clk) begin
        if (m_axi_awvalid && m_axi_awready) aw_hs_cnt++;
        if (m_axi_arvalid && m_axi_arready) ar_hs_cnt++;
        if (m_axi_wvalid && m_axi_wready)   w_hs_cnt++;
        if (rd_valid && rd_ready)           rd_hs_cnt++;
        if (done)                           done_cnt++;
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        check1("cmd_ready_idle", cmd_ready, 1'b1);
        next_cycle();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
    endtask

    task automatic run_reject(input logic wr, input logic [AW-1:0] a, input logic [7:0] l);
        int aw0;
        int ar0;
        int d0;
        aw0 = aw_hs_cnt;
        ar0 = ar_hs_cnt;
        d0  = done_cnt;
        wr_valid      = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_awready = 1'b1;
        m_axi_arready = 1'b1;
        send_cmd(wr, a, l);
        #1;
        check1("cmd_err_pulse", cmd_err, 1'b1);
        check32("rej_state", 32'(dbg_state), 32'(ST_IDLE));
        check1("rej_awvalid", m_axi_awvalid, 1'b0);
        check1("rej_arvalid", m_axi_arvalid, 1'b0);
        check1("rej_wr_ready", wr_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #1;
            check1("rej_cmd_err_low", cmd_err, 1'b0);
            check1("rej_no_axvalid", m_axi_awvalid | m_axi_arvalid | m_axi_wvalid, 1'b0);
        end
        check32("rej_aw_count", aw_hs_cnt, aw0);
        check32("rej_ar_count", ar_hs_cnt, ar0);
        check32("rej_done_count", done_cnt, d0);
        wr_valid      = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_arready = 1'b0;
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [7:0] l,
                             input logic [31:0] seed, input logic [31:0] step,
                             input int aw_wait);
        int aw0;
        int w0;
        int beat;
        int cyc;
        logic hs;
        logic [31:0] exp_w;
        aw0 = aw_hs_cnt;
        w0  = w_hs_cnt;
        send_cmd(1'b1, a, l);
        wr_valid     = 1'b1;
        m_axi_wready = 1'b1;
        for (int k = 0; k < aw_wait; k++) begin
            m_axi_awready = 1'b0;
            #1;
            check1("aw_hold_valid", m_axi_awvalid, 1'b1);
            check1("aw_phase_wready_gated", wr_ready, 1'b0);
            next_cycle();
        end
        m_axi_awready = 1'b1;
        #1;
        check1("awvalid", m_axi_awvalid, 1'b1);
        check32("awaddr", 32'(m_axi_awaddr), 32'(a & 14'h3FFC));
        check32("awlen", 32'(m_axi_awlen), 32'(l));
        next_cycle();
        m_axi_awready = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(l) && cyc < 1000) begin
            exp_w        = seed + 32'(beat) * step;
            wr_valid     = 1'b1;
            wr_data      = exp_w;
            m_axi_wready = (cyc % 3) != 1;
            #1;
            check1("wvalid", m_axi_wvalid, 1'b1);
            check1("wr_ready_pass", wr_ready, m_axi_wready);
            check32("wdata", m_axi_wdata, exp_w);
            check32("wstrb", 32'(m_axi_wstrb), 32'hF);
            check1("wlast", m_axi_wlast, beat == int'(l));
            check1("w_done_low", done, 1'b0);
            hs = m_axi_wready;
            next_cycle();
            if (hs) beat++;
            cyc++;
        end
        wr_valid     = 1'b0;
        m_axi_wready = 1'b0;
        #1;
        check32("w_beats", beat, int'(l) + 1);
        check1("w_done_pulse", done, 1'b1);
        check32("w_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check1("w_cmd_ready_with_done", cmd_ready, 1'b1);
        check32("w_aw_count", aw_hs_cnt, aw0 + 1);
        check32("w_hs_count", w_hs_cnt, w0 + int'(l) + 1);
        next_cycle();
        #1;
        check1("w_done_one_cycle", done, 1'b0);
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [31:0] seed, input logic [31:0] step,
                            input logic bp, input int bad_resp_beat,
                            input int bad_rlast_beat, input int ar_wait);
        int ar0;
        int r0;
        int beat;
        int cyc;
        logic hs;
        logic [31:0] exp_r;
        ar0 = ar_hs_cnt;
        r0  = rd_hs_cnt;
        exp_q.delete();
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(seed + 32'(i) * step);
        send_cmd(1'b0, a, l);
        m_axi_rvalid = 1'b1;
        rd_ready     = 1'b1;
        for (int k = 0; k < ar_wait; k++) begin
            m_axi_arready = 1'b0;
            #1;
            check1("ar_hold_valid", m_axi_arvalid, 1'b1);
            check1("ar_phase_rd_valid_gated", rd_valid, 1'b0);
            next_cycle();
        end
        m_axi_arready = 1'b1;
        #1;
        check1("arvalid", m_axi_arvalid, 1'b1);
        check32("araddr", 32'(m_axi_araddr), 32'(a & 14'h3FFC));
        check32("arlen", 32'(m_axi_arlen), 32'(l));
        next_cycle();
        m_axi_arready = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(l) && cyc < 1000) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = seed + 32'(beat) * step;
            m_axi_rresp  = (beat == bad_resp_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            m_axi_rlast  = (beat == bad_rlast_beat) ? (beat != int'(l)) : (beat == int'(l));
            rd_ready     = bp ? ((cyc % 2) == 0) : 1'b1;
            #1;
            check1("rd_valid_pass", rd_valid, 1'b1);
            check1("rready_mirror", m_axi_rready, rd_ready);
            check1("rd_last", rd_last, beat == int'(l));
            check1("r_done_low", done, 1'b0);
            hs = rd_ready;
            if (hs) begin
                exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check32("rd_data", rd_data, exp_r);
            end
            next_cycle();
            if (hs) beat++;
            cyc++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = AXI_RESP_OKAY;
        rd_ready     = 1'b0;
        #1;
        check32("r_beats", beat, int'(l) + 1);
        check1("r_done_pulse", done, 1'b1);
        check32("r_end_state", 32'(dbg_state), 32'(ST_IDLE));
        check32("r_ar_count", ar_hs_cnt, ar0 + 1);
        check32("r_hs_count", rd_hs_cnt, r0 + int'(l) + 1);
        check32("r_queue_empty", exp_q.size(), 0);
        next_cycle();
        #1;
        check1("r_done_one_cycle", done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic          rej;
        logic [31:0]   seed;
        logic [31:0]   step;
        int            wait_cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 14'h0000, 8'd3,  1'b0, 32'h11,        32'h11,  0};
        vecs[1] = '{1'b0, 14'h0100, 8'd1,  1'b0, 32'hA,         32'h1,   0};
        vecs[2] = '{1'b1, 14'h3FFC, 8'd1,  1'b1, 32'h0,         32'h0,   0};
        vecs[3] = '{1'b0, 14'h3FF0, 8'd4,  1'b1, 32'h0,         32'h0,   0};
        vecs[4] = '{1'b0, 14'h3FFC, 8'd0,  1'b0, 32'h5A5A0000,  32'h0,   1};
        vecs[5] = '{1'b1, 14'h0203, 8'd0,  1'b0, 32'hCAFEF00D,  32'h0,   2};
        vecs[6] = '{1'b1, 14'h3FC0, 8'd15, 1'b0, 32'h1000,      32'h100, 1};

        rst = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b1; rd_ready = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bresp = AXI_RESP_OKAY; m_axi_bvalid = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = AXI_RESP_OKAY; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b1;
        repeat (3) next_cycle();
        #1;
        check32("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        check1("reset_cmd_ready", cmd_ready, 1'b0);
        check1("reset_awvalid", m_axi_awvalid, 1'b0);
        check1("reset_arvalid", m_axi_arvalid, 1'b0);
        check1("reset_wvalid", m_axi_wvalid, 1'b0);
        check1("reset_rready", m_axi_rready, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_cmd_err", cmd_err, 1'b0);
        check1("reset_err", err, 1'b0);
        cmd_valid = 1'b0; cmd_write = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rej)
                run_reject(vecs[i].wr, vecs[i].addr, vecs[i].len);
            else if (vecs[i].wr)
                run_write(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].step, vecs[i].wait_cyc);
            else
                run_read(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].step, 1'b0, -1, -1,
                         vecs[i].wait_cyc);
            check1("vec_err_clear", err, 1'b0);
        end

        // RRESP error on beat 1 latches err; later commands still run.
        run_read(14'h0080, 8'd2, 32'h100, 32'h1, 1'b0, 1, -1, 0);
        check1("rresp_err_set", err, 1'b1);
        run_write(14'h0010, 8'd1, 32'h77, 32'h1, 0);
        check1("rresp_err_sticky", err, 1'b1);

        // Reset in the middle of a 4-beat write burst.
        begin
            int d0;
            int w0;
            d0 = done_cnt;
            w0 = w_hs_cnt;
            send_cmd(1'b1, 14'h0040, 8'd3);
            m_axi_awready = 1'b1;
            next_cycle();
            m_axi_awready = 1'b0;
            for (int b = 0; b < 2; b++) begin
                wr_valid = 1'b1; wr_data = 32'h0BEE0000 + 32'(b); m_axi_wready = 1'b1;
                next_cycle();
            end
            check32("rstw_two_beats", w_hs_cnt, w0 + 2);
            m_axi_wready = 1'b0;
            rst = 1'b1;
            next_cycle();
            #1;
            check1("rstw_wvalid_drop", m_axi_wvalid, 1'b0);
            check32("rstw_state", 32'(dbg_state), 32'(ST_IDLE));
            check1("rstw_cmd_ready_in_rst", cmd_ready, 1'b0);
            rst = 1'b0;
            m_axi_wready = 1'b1;
            #1;
            check1("rstw_cmd_ready_after", cmd_ready, 1'b1);
            check1("rstw_err_cleared", err, 1'b0);
            for (int k = 0; k < 3; k++) begin
                next_cycle();
                #1;
                check1("rstw_wr_ready_gated", wr_ready, 1'b0);
                check1("rstw_no_done", done, 1'b0);
            end
            check32("rstw_done_count", done_cnt, d0);
            wr_valid = 1'b0;
            m_axi_wready = 1'b0;
        end

        // 8-beat read with rd_ready toggling every cycle.
        run_read(14'h0200, 8'd7, 32'hB0, 32'h4, 1'b1, -1, -1, 2);
        check1("bp_err_clear", err, 1'b0);

        // RLAST raised early on beat 0 of a 2-beat read.
        run_read(14'h0300, 8'd1, 32'h3000, 32'h10, 1'b0, -1, 0, 0);
        check1("rlast_mismatch_err", err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
